// File: rtl/seq01_tx.sv
// rtl/seq01_tx.sv - "01"-framed MSB-first serial transmitter with 0->1 edge counter
module seq01_tx #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             busy,
  output logic             x_out,
  output logic             frame,
  output logic             done,
  output logic [CNTW-1:0]  edge_cnt
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, PRE0, PRE1, DATA, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [CNTW-1:0]  edge_cnt_n;
  logic             x_n, busy_n, frame_n, done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      edge_cnt <= '0;
      x_out    <= 1'b1;
      busy     <= 1'b0;
      frame    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_cnt  <= bit_cnt_n;
      edge_cnt <= edge_cnt_n;
      x_out    <= x_n;
      busy     <= busy_n;
      frame    <= frame_n;
      done     <= done_n;
    end
  end

  // Outputs are decoded from the next state so they appear registered with that state.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_cnt_n  = bit_cnt;
    edge_cnt_n = edge_cnt;
    x_n        = 1'b1;
    busy_n     = 1'b0;
    frame_n    = 1'b0;
    done_n     = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (load) begin
          state_n    = PRE0;
          shift_n    = din;
          edge_cnt_n = '0;
        end else begin
          state_n = IDLE;
        end
      end
      PRE0: state_n = PRE1;
      PRE1: begin
        state_n   = DATA;
        bit_cnt_n = '0;
      end
      DATA: begin
        if (bit_cnt == BW'(WIDTH - 1)) state_n = DONE;
        else bit_cnt_n = bit_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      PRE0: begin
        x_n    = 1'b0;
        busy_n = 1'b1;
      end
      PRE1: busy_n = 1'b1;
      DATA: begin
        x_n     = shift[WIDTH-1];
        shift_n = {shift[WIDTH-2:0], 1'b0};
        busy_n  = 1'b1;
        frame_n = 1'b1;
      end
      DONE: done_n = 1'b1;
      default: ;
    endcase

    // Only rising transitions inside a frame count; the idle line never produces one.
    if (state_n != IDLE && x_n && !x_out)
      edge_cnt_n = edge_cnt + 1'b1;
  end

endmodule

// File: tb/tb_seq01_tx.sv
// tb/tb_seq01_tx.sv - directed self-checking bench for seq01_tx
module tb_seq01_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] din;
  logic       busy, x_out, frame, done;
  logic [3:0] edge_cnt;

  int checks = 0;
  int errors = 0;

  logic det_prev = 1'b1;
  int   det_cnt  = 0;

  seq01_tx #(.WIDTH(8), .CNTW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .load     (load),
    .busy     (busy),
    .x_out    (x_out),
    .frame    (frame),
    .done     (done),
    .edge_cnt (edge_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural Mealy "01" detector on the serial line.
  always @(negedge clk) begin
    if (rst) det_prev = 1'b1;
    else begin
      if (x_out && !det_prev) det_cnt = det_cnt + 1;
      det_prev = x_out;
    end
  end

  function automatic logic [10:0] model_stream(input logic [7:0] d);
    return {2'b01, d, 1'b1};
  endfunction

  function automatic logic [3:0] model_edges(input logic [7:0] d);
    logic [10:0] s;
    logic        p;
    int          n;
    s = model_stream(d);
    p = 1'b1;
    n = 0;
    for (int i = 10; i >= 0; i--) begin
      if (s[i] && !p) n++;
      p = s[i];
    end
    return 4'(n);
  endfunction

  task automatic run_frame(input logic [7:0] d, output logic [10:0] xs, output logic [10:0] fr,
                           output logic [10:0] dn, output logic [10:0] bz, output logic [3:0] ec);
    @(negedge clk);
    din  = d;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    din  = ~d;
    ec   = 4'hF;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      xs[10-i] = x_out;
      fr[10-i] = frame;
      dn[10-i] = done;
      bz[10-i] = busy;
      if (done) ec = edge_cnt;
    end
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    load = 1'b0;
    din  = 8'h00;
    #12;
    checks++;
    if ({x_out, busy, frame, done, edge_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset_state got x=%b busy=%b frame=%b done=%b cnt=%0d want 1 0 0 0 0",
               x_out, busy, frame, done, edge_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_frame;
    logic bad_done, bad_x;
    @(negedge clk);
    din  = 8'hA5;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({x_out, frame, edge_cnt} !== {1'b0, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL pre_reset_data got x=%b frame=%b cnt=%0d want 0 1 1", x_out, frame, edge_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({x_out, busy, frame, done, edge_cnt} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL async_reset got x=%b busy=%b frame=%b done=%b cnt=%0d want 1 0 0 0 0",
               x_out, busy, frame, done, edge_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    bad_done = 1'b0;
    bad_x    = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (done) bad_done = 1'b1;
      if (!x_out || busy) bad_x = 1'b1;
    end
    checks++;
    if (bad_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done got done_seen=%b want 0", bad_done);
    end
    checks++;
    if (bad_x !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got activity=%b want 0", bad_x);
    end
  endtask

  task automatic test_single_frame;
    logic [10:0] xs, fr, dn, bz;
    logic [3:0]  ec;
    run_frame(8'hA5, xs, fr, dn, bz, ec);
    checks++;
    if (xs !== 11'b01101001011) begin
      errors++;
      $display("FAIL a5_stream got %b want 01101001011", xs);
    end
    checks++;
    if (fr !== 11'b00111111110) begin
      errors++;
      $display("FAIL a5_frame got %b want 00111111110", fr);
    end
    checks++;
    if (dn !== 11'b00000000001) begin
      errors++;
      $display("FAIL a5_done got %b want 00000000001", dn);
    end
    checks++;
    if (bz !== 11'b11111111110) begin
      errors++;
      $display("FAIL a5_busy got %b want 11111111110", bz);
    end
    checks++;
    if (ec !== 4'd4) begin
      errors++;
      $display("FAIL a5_edge_cnt got %0d want 4", ec);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({edge_cnt, busy, x_out} !== {4'd4, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL a5_hold got cnt=%0d busy=%b x=%b want 4 0 1", edge_cnt, busy, x_out);
    end
  endtask

  task automatic test_boundary_words;
    logic [7:0]  words [3] = '{8'h00, 8'hFF, 8'h55};
    logic [3:0]  exp_ec[3] = '{4'd2, 4'd1, 4'd5};
    logic [10:0] exp_xs[3] = '{11'b01000000001, 11'b01111111111, 11'b01010101011};
    logic [10:0] xs, fr, dn, bz;
    logic [3:0]  ec;
    for (int k = 0; k < 3; k++) begin
      run_frame(words[k], xs, fr, dn, bz, ec);
      checks++;
      if (xs !== exp_xs[k]) begin
        errors++;
        $display("FAIL boundary_stream word=%h got %b want %b", words[k], xs, exp_xs[k]);
      end
      checks++;
      if (ec !== exp_ec[k]) begin
        errors++;
        $display("FAIL boundary_edge_cnt word=%h got %0d want %0d", words[k], ec, exp_ec[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [21:0] xs, dn, bz;
    logic [3:0]  ec1, ec2;
    @(negedge clk);
    din  = 8'hA5;
    load = 1'b1;
    @(posedge clk);
    #1;
    din = 8'h3C;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      xs[21-i] = x_out;
      dn[21-i] = done;
      bz[21-i] = busy;
      if (i == 10) ec1 = edge_cnt;
      if (i == 21) begin
        ec2  = edge_cnt;
        load = 1'b0;
      end
    end
    checks++;
    if (xs !== {11'b01101001011, 11'b01001111001}) begin
      errors++;
      $display("FAIL b2b_stream got %b want 0110100101101001111001", xs);
    end
    checks++;
    if (dn !== 22'b0000000000100000000001) begin
      errors++;
      $display("FAIL b2b_done got %b want 0000000000100000000001", dn);
    end
    checks++;
    if (bz !== 22'b1111111111011111111110) begin
      errors++;
      $display("FAIL b2b_busy got %b want 1111111111011111111110", bz);
    end
    checks++;
    if ({ec1, ec2} !== {4'd4, 4'd3}) begin
      errors++;
      $display("FAIL b2b_edge_cnt got %0d,%0d want 4,3", ec1, ec2);
    end
    @(negedge clk);
    checks++;
    if ({busy, x_out, edge_cnt} !== {1'b0, 1'b1, 4'd3}) begin
      errors++;
      $display("FAIL b2b_idle got busy=%b x=%b cnt=%0d want 0 1 3", busy, x_out, edge_cnt);
    end
  endtask

  task automatic test_ignored_load;
    logic [10:0] xs, bz;
    logic [3:0]  ec;
    @(negedge clk);
    din  = 8'h00;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    ec   = 4'hF;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      xs[10-i] = x_out;
      bz[10-i] = busy;
      if (done) ec = edge_cnt;
      if (i == 4) begin
        din  = 8'hFF;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
      end
    end
    checks++;
    if (xs !== 11'b01000000001) begin
      errors++;
      $display("FAIL ignored_stream got %b want 01000000001", xs);
    end
    checks++;
    if (bz !== 11'b11111111110) begin
      errors++;
      $display("FAIL ignored_busy got %b want 11111111110", bz);
    end
    checks++;
    if (ec !== 4'd2) begin
      errors++;
      $display("FAIL ignored_edge_cnt got %0d want 2", ec);
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({busy, x_out} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ignored_no_queue got busy=%b x=%b want 0 1", busy, x_out);
    end
  endtask

  task automatic test_loopback;
    logic [10:0] xs, fr, dn, bz;
    logic [3:0]  ec;
    logic [7:0]  w;
    int          base, sum, bad;
    @(negedge clk);
    base = det_cnt;
    sum  = 0;
    bad  = 0;
    for (int k = 0; k < 20; k++) begin
      w = 8'($urandom);
      run_frame(w, xs, fr, dn, bz, ec);
      sum += int'(ec);
      if (ec !== model_edges(w) || xs !== model_stream(w)) begin
        bad++;
        $display("FAIL loop_frame word=%h got cnt=%0d stream=%b want cnt=%0d stream=%b",
                 w, ec, xs, model_edges(w), model_stream(w));
      end
    end
    checks++;
    if (bad != 0) errors++;
    repeat (2) @(negedge clk);
    checks++;
    if (det_cnt - base != sum) begin
      errors++;
      $display("FAIL loop_detector got %0d want %0d", det_cnt - base, sum);
    end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_boundary_words;
    test_back_to_back;
    test_ignored_load;
    test_reset_mid_frame;
    test_loopback;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
